display_scroll_ctrl: RTL and testbench

DISPLAY_SCROLL_CTRL -- requirements
Module: display_scroll_ctrl

---
 rtl/display_scroll_ctrl.sv | 160 ++++++++++++++++
 tb/tb_display_scroll_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scroll_ctrl.sv
// rtl/display_scroll_ctrl.sv - UART byte FIFO feeding a nibble-scrolling 4-digit LED display
// Bytes are queued, then shifted in high nibble first, one nibble per SCROLL_DIV enabled cycles.
module display_scroll_ctrl #(
  parameter int SCROLL_DIV = 16,
  parameter int ERR_HOLD   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_VALID,
  input  logic        FERROR,
  input  logic        PERROR,
  input  logic        scroll_en,
  input  logic        clr,
  output logic [15:0] Char_to_Display,
  output logic        disp_update,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow,
  output logic        busy
);

  localparam int DW = $clog2(SCROLL_DIV);
  localparam int EW = $clog2(ERR_HOLD + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCROLL_DIV - 1);
  localparam logic [EW-1:0] ERR_LAST = EW'(ERR_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_HI, SHIFT_LO, ERROR} state_t;

  state_t          state;
  logic [7:0]      mem [8];
  logic [2:0]      wr_ptr;
  logic [2:0]      rd_ptr;
  logic [3:0]      count;
  logic [7:0]      hold;
  logic [DW-1:0]   div_cnt;
  logic [EW-1:0]   err_cnt;

  logic clean_byte;
  logic err_byte;
  logic wr_en;
  logic pop;
  logic step;

  assign clean_byte = Rx_VALID & ~FERROR & ~PERROR;
  assign err_byte   = Rx_VALID & (FERROR | PERROR);
  assign fifo_full  = (count == 4'd8);
  assign fifo_empty = (count == 4'd0);
  // Full is judged on the pre-pop count, so a write into a full FIFO is lost even if a pop frees a slot.
  assign wr_en      = clean_byte & ~clr & ~fifo_full;
  assign pop        = (state == IDLE) & scroll_en & ~fifo_empty & ~clr & ~err_byte;
  assign step       = (div_cnt == DIV_LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= Rx_Data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 3'd1;
      if (pop)   rd_ptr <= rd_ptr + 3'd1;
      if (clean_byte && fifo_full) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      div_cnt         <= '0;
      err_cnt         <= '0;
      hold            <= '0;
      Char_to_Display <= 16'hFFFF;
      disp_update     <= 1'b0;
    end else begin
      disp_update <= 1'b0;
      if (clr) begin
        state           <= IDLE;
        div_cnt         <= '0;
        err_cnt         <= '0;
        Char_to_Display <= 16'hFFFF;
        disp_update     <= 1'b1;
      end else if (err_byte) begin
        state           <= ERROR;
        div_cnt         <= '0;
        err_cnt         <= '0;
        hold            <= '0;
        Char_to_Display <= 16'hAAAA;
        disp_update     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              hold    <= mem[rd_ptr];
              div_cnt <= '0;
              state   <= SHIFT_HI;
            end
          end
          SHIFT_HI: begin
            if (scroll_en) begin
              if (step) begin
                Char_to_Display <= {Char_to_Display[11:0], hold[7:4]};
                disp_update     <= 1'b1;
                div_cnt         <= '0;
                state           <= SHIFT_LO;
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end
          end
          SHIFT_LO: begin
            if (scroll_en) begin
              if (step) begin
                Char_to_Display <= {Char_to_Display[11:0], hold[3:0]};
                disp_update     <= 1'b1;
                div_cnt         <= '0;
                state           <= IDLE;
              end else begin
                div_cnt <= div_cnt + 1'b1;
              end
            end
          end
          ERROR: begin
            // The error pattern ignores scroll_en so a frozen display cannot hide the fault forever.
            if (step) begin
              div_cnt <= '0;
              if (err_cnt == ERR_LAST) begin
                err_cnt         <= '0;
                Char_to_Display <= 16'hFFFF;
                disp_update     <= 1'b1;
                state           <= IDLE;
              end else begin
                err_cnt <= err_cnt + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// tb/tb_display_scroll_ctrl.sv - directed and randomized bench for display_scroll_ctrl
module tb_display_scroll_ctrl;

  localparam int DIV = 4;
  localparam int EH  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        ferr = 1'b0;
  logic        perr = 1'b0;
  logic        sen = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] char_out;
  logic        disp_update;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad = 0;

  display_scroll_ctrl #(.SCROLL_DIV(DIV), .ERR_HOLD(EH)) dut (
    .clk(clk), .reset(reset), .Rx_Data(rx_data), .Rx_VALID(rx_valid),
    .FERROR(ferr), .PERROR(perr), .scroll_en(sen), .clr(clr),
    .Char_to_Display(char_out), .disp_update(disp_update),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus elapsed-cycle counts since the last pop or error.
  logic [7:0]  m_q[$];
  logic [15:0] m_disp;
  logic        m_upd;
  logic        m_ovf;
  int          m_mode;   // 0 idle, 1 scrolling a byte, 2 showing error
  int          m_prog;
  logic [7:0]  m_byte;
  logic [15:0] shown[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_disp = 16'hFFFF;
    m_upd  = 1'b0;
    m_ovf  = 1'b0;
    m_mode = 0;
    m_prog = 0;
    m_byte = 8'h00;
  endtask

  task automatic model_step();
    int  pre;
    bit  clean;
    bit  errb;
    pre   = m_q.size();
    clean = rx_valid && !ferr && !perr;
    errb  = rx_valid && (ferr || perr);
    m_upd = 1'b0;
    if (clr) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_disp = 16'hFFFF;
      m_upd  = 1'b1;
      m_mode = 0;
    end else begin
      if (errb) begin
        m_disp = 16'hAAAA;
        m_upd  = 1'b1;
        m_mode = 2;
        m_prog = 0;
      end else if (m_mode == 0) begin
        if (sen && pre > 0) begin
          m_byte = m_q.pop_front();
          m_mode = 1;
          m_prog = 0;
        end
      end else if (m_mode == 1) begin
        if (sen) begin
          m_prog++;
          if (m_prog == DIV) begin
            m_disp = (m_disp << 4) | 16'(m_byte >> 4);
            m_upd  = 1'b1;
          end else if (m_prog == 2 * DIV) begin
            m_disp = (m_disp << 4) | 16'(m_byte & 8'h0F);
            m_upd  = 1'b1;
            m_mode = 0;
          end
        end
      end else begin
        m_prog++;
        if (m_prog == EH * DIV) begin
          m_disp = 16'hFFFF;
          m_upd  = 1'b1;
          m_mode = 0;
        end
      end
      if (clean) begin
        if (pre == 8) m_ovf = 1'b1;
        else m_q.push_back(rx_data);
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".disp"}, 32'(char_out), 32'(m_disp));
    chk({tag, ".upd"}, 32'(disp_update), 32'(m_upd));
    chk({tag, ".full"}, 32'(fifo_full), 32'(m_q.size() == 8));
    chk({tag, ".empty"}, 32'(fifo_empty), 32'(m_q.size() == 0));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, ".disp"}, 32'(char_out), 32'h0000FFFF);
    chk({tag, ".upd"}, 32'(disp_update), 32'd0);
    chk({tag, ".empty"}, 32'(fifo_empty), 32'd1);
    chk({tag, ".full"}, 32'(fifo_full), 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic drive(bit v, logic [7:0] d, bit f, bit p, bit s, bit c);
    rx_valid = v;
    rx_data  = d;
    ferr     = f;
    perr     = p;
    sen      = s;
    clr      = c;
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    if (disp_update) shown.push_back(char_out);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;

    // Two clean bytes scroll through as FFF1, FF12, F123, 1234.
    shown.delete();
    drive(1, 8'h12, 0, 0, 1, 0); tick("s30a");
    drive(1, 8'h34, 0, 0, 1, 0); tick("s30b");
    drive(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 4 * DIV + 4; i++) tick("s30run");
    chk("s30.npulse", 32'(shown.size()), 32'd4);
    if (shown.size() == 4) begin
      chk("s30.v0", 32'(shown[0]), 32'h0000FFF1);
      chk("s30.v1", 32'(shown[1]), 32'h0000FF12);
      chk("s30.v2", 32'(shown[2]), 32'h0000F123);
      chk("s30.v3", 32'(shown[3]), 32'h00001234);
    end

    // Nine bytes while frozen: eighth fills, ninth overflows.
    drive(0, 8'h00, 0, 0, 0, 1); tick("s31clr");
    for (int i = 0; i < 9; i++) begin
      drive(1, 8'(8'h40 + i), 0, 0, 0, 0); tick("s31wr");
      if (i == 7) chk("s31.full8", 32'(fifo_full), 32'd1);
    end
    chk("s31.ovf", 32'(overflow), 32'd1);
    chk("s31.full", 32'(fifo_full), 32'd1);

    // Write and pop together while full: write dropped, one entry leaves.
    drive(1, 8'h99, 0, 0, 1, 0); tick("s34full");
    chk("s34.notfull", 32'(fifo_full), 32'd0);
    chk("s34.ovf", 32'(overflow), 32'd1);
    chk("s34.busy", 32'(busy), 32'd1);

    // clr with Rx_VALID and three queued entries.
    drive(0, 8'h00, 0, 0, 0, 1); tick("s33clr0");
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h21 + i), 0, 0, 0, 0); tick("s33wr");
    end
    drive(1, 8'h77, 0, 0, 1, 1); tick("s33clr");
    chk("s33.empty", 32'(fifo_empty), 32'd1);
    chk("s33.disp", 32'(char_out), 32'h0000FFFF);
    drive(0, 8'h00, 0, 0, 1, 0); tick("s33idle");
    chk("s33.busy", 32'(busy), 32'd0);

    // Errored byte during SHIFT_LO, then recovery and resumed scrolling.
    drive(1, 8'h56, 0, 0, 1, 0); tick("s32w0");
    drive(1, 8'h78, 0, 0, 1, 0); tick("s32w1");
    drive(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < DIV + 1; i++) tick("s32hi");
    drive(1, 8'h00, 0, 1, 1, 0); tick("s32err");
    chk("s32.aaaa", 32'(char_out), 32'h0000AAAA);
    drive(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < EH * DIV - 1; i++) tick("s32hold");
    chk("s32.still", 32'(char_out), 32'h0000AAAA);
    tick("s32exit");
    chk("s32.ffff", 32'(char_out), 32'h0000FFFF);
    for (int i = 0; i < 2 * DIV + 1; i++) tick("s32resume");
    chk("s32.ff78", 32'(char_out), 32'h0000FF78);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit v;
      v = ($urandom_range(0, 99) < 35);
      drive(v, 8'($urandom), v && ($urandom_range(0, 99) < 5), v && ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 2));
      tick("rand");
    end

    // Reset pulsed mid-SHIFT_HI takes effect without a clock edge.
    drive(0, 8'h00, 0, 0, 1, 1); tick("s35clr");
    drive(1, 8'hC3, 0, 0, 1, 0); tick("s35w");
    drive(0, 8'h00, 0, 0, 1, 0); tick("s35pop");
    tick("s35shift");
    chk("s35.busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_values("s35async");
    @(negedge clk);
    reset = 1'b1;
    drive(1, 8'h5A, 0, 0, 0, 0); tick("s35after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
